// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode types: the fetchStruct pair handed from fetch to decode
// and the fetch-width constants used by the fetch stage.
package typedefs;

  localparam int unsigned FETCH_WIDTH = 2;           // instructions per pair
  localparam int unsigned FETCH_BYTES = 8;           // bytes consumed per pair
  localparam logic [31:0] NOP_WORD    = 32'h0;       // opcode 0, a bubble in decode

  typedef struct packed {
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } fetchStruct;

endpackage

// File: rtl/fetch_skid.sv
// One-entry fetchStruct holding register. Catches a response that arrives
// while decode is stalled so it is not lost; drain empties it.
module fetch_skid
  import typedefs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_drain,
  input  fetchStruct i_data,
  output fetchStruct o_data,
  output logic       o_valid
);

  fetchStruct r_data;
  logic       r_valid;

  // Capture on load, clear on drain or reset (drain wins over load).
  always_ff @(posedge clk) begin
    if (reset || i_drain) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: owns the PC, issues paired reads to a synchronous
// instruction memory, buffers one response under stall and drives fd_reg.
// Optional feature: define FETCH_REDIRECT_EN to add redirect_valid/redirect_pc.
module fetch_unit
  import typedefs::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr_a,
  output logic [31:0] imem_addr_b,
  input  logic [31:0] imem_rdata_a,
  input  logic [31:0] imem_rdata_b,
  output fetchStruct  fd_reg,
  output logic        fd_valid,
  output logic        done
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`endif
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);
  localparam logic [31:0] PC_STEP  = 32'(FETCH_BYTES);
  localparam fetchStruct  BUBBLE   = '{inst_a: NOP_WORD, inst_b: NOP_WORD,
                                       pc_a: 32'h0, pc_b: 32'h0};

  logic [31:0] r_pc;
  logic        r_running;
  logic        r_inflight;
  fetchStruct  r_fd;
  logic        r_fd_valid;
  logic        r_done;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_next;
  fetchStruct  w_response;
  fetchStruct  w_skid_data;
  logic        w_skid_valid;
  logic        w_skid_load;
  logic        w_skid_drain;

`ifdef FETCH_REDIRECT_EN
  assign w_redirect    = redirect_valid;
  assign w_redirect_pc = redirect_pc;
`else
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = RESET_PC;
`endif

  assign imem_req    = r_running && !stall && !reset && !w_redirect;
  assign imem_addr_a = r_pc;
  assign imem_addr_b = r_pc + 32'd4;
  assign w_pc_next   = r_pc + PC_STEP;

  // The pc has already advanced past the pair whose data arrives now.
  assign w_response = '{inst_a: imem_rdata_a, inst_b: imem_rdata_b,
                        pc_a: r_pc - PC_STEP, pc_b: r_pc - 32'd4};

  // Fill only when a response arrives that decode cannot take this edge.
  assign w_skid_load  = !reset && !w_redirect && stall && r_inflight;
  assign w_skid_drain = w_redirect || (!stall && w_skid_valid);

  fetch_skid u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_data  (w_response),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  // PC advance, halt detection, fd_reg update and sticky done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_running  <= 1'b1;
      r_inflight <= 1'b0;
      r_fd       <= BUBBLE;
      r_fd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_redirect_pc;
      r_running  <= w_redirect_pc < PC_LIMIT;
      r_inflight <= 1'b0;
      r_fd       <= BUBBLE;
      r_fd_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (imem_req) begin
        r_pc      <= w_pc_next;
        r_running <= w_pc_next < PC_LIMIT;
      end
      r_inflight <= imem_req;
      if (!stall) begin
        if (w_skid_valid) begin
          r_fd       <= w_skid_data;
          r_fd_valid <= 1'b1;
        end else if (r_inflight) begin
          r_fd       <= w_response;
          r_fd_valid <= 1'b1;
        end else begin
          r_fd       <= BUBBLE;
          r_fd_valid <= 1'b0;
        end
      end
      r_done <= r_done || (!r_running && !r_inflight && !w_skid_valid && !r_fd_valid);
    end
  end

  assign fd_reg   = r_fd;
  assign fd_valid = r_fd_valid;
  assign done     = r_done;

  // Skid only fills under stall, and a stall cycle issues no request.
  a_skid_inflight_excl: assert property (@(posedge clk) disable iff (reset)
    !(w_skid_valid && r_inflight));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table from reset, randomized stall run checked
// against an in-order pair-stream model, and hand-written corner sequences.
module tb_fetch_unit;
  import typedefs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Full-size instance
  logic        reset, stall, imem_req, fd_valid, done;
  logic [31:0] imem_addr_a, imem_addr_b;
  logic [31:0] imem_rdata_a = '0, imem_rdata_b = '0;
  fetchStruct  fd_reg;
`ifdef FETCH_REDIRECT_EN
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`endif

  // Small instance for end-of-program
  logic        s_reset, s_stall, s_imem_req, s_fd_valid, s_done;
  logic [31:0] s_addr_a, s_addr_b;
  logic [31:0] s_rdata_a = '0, s_rdata_b = '0;
  fetchStruct  s_fd;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.IMEM_DEPTH(256), .RESET_PC(32'h0)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr_a  (imem_addr_a),
    .imem_addr_b  (imem_addr_b),
    .imem_rdata_a (imem_rdata_a),
    .imem_rdata_b (imem_rdata_b),
    .fd_reg       (fd_reg),
    .fd_valid     (fd_valid),
    .done         (done)
`ifdef FETCH_REDIRECT_EN
    ,
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`endif
  );

  fetch_unit #(.IMEM_DEPTH(8), .RESET_PC(32'h0)) u_dut_small (
    .clk          (clk),
    .reset        (s_reset),
    .stall        (s_stall),
    .imem_req     (s_imem_req),
    .imem_addr_a  (s_addr_a),
    .imem_addr_b  (s_addr_b),
    .imem_rdata_a (s_rdata_a),
    .imem_rdata_b (s_rdata_b),
    .fd_reg       (s_fd),
    .fd_valid     (s_fd_valid),
    .done         (s_done)
`ifdef FETCH_REDIRECT_EN
    ,
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
`endif
  );

  // Program image: word i holds 0x100 + i.
  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction

  // Synchronous-read memories, one cycle latency.
  always @(posedge clk) begin
    if (imem_req) begin
      imem_rdata_a <= inst_of(imem_addr_a);
      imem_rdata_b <= inst_of(imem_addr_b);
    end
    if (s_imem_req) begin
      s_rdata_a <= inst_of(s_addr_a);
      s_rdata_b <= inst_of(s_addr_b);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decode must see pairs pc_a = 0, 8, 16, ... strictly in order.
  logic [31:0] exp_pc;
  int          consumed;
  fetchStruct  prev_fd;
  logic        prev_fdv;
  logic        prev_stall;

  task automatic cycle_sb(input logic st);
    stall = st;
    #1;
    if (prev_stall) begin
      chk("hold.pc_a", fd_reg.pc_a, prev_fd.pc_a);
      chk("hold.valid", fd_valid, prev_fdv);
    end
    if (fd_valid && !st) begin
      chk("seq.pc_a", fd_reg.pc_a, exp_pc);
      chk("seq.pc_b", fd_reg.pc_b, exp_pc + 32'd4);
      chk("seq.inst_a", fd_reg.inst_a, inst_of(exp_pc));
      chk("seq.inst_b", fd_reg.inst_b, inst_of(exp_pc + 32'd4));
      exp_pc = exp_pc + 32'd8;
      consumed++;
    end
    if (!fd_valid)
      chk("bubble.zero", fd_reg.inst_a | fd_reg.inst_b | fd_reg.pc_a | fd_reg.pc_b, 32'h0);
    prev_fd    = fd_reg;
    prev_fdv   = fd_valid;
    prev_stall = st;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        fdv;
    logic [31:0] pc_a;
  } vec_t;

  vec_t tbl[11];
  int   c0;

  initial begin
    // Plain run C0..C3, then a 3-cycle stall while pc_a 16 is held (C4..C6).
    tbl[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 32'd8,  1'b0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd8};
    tbl[4]  = '{1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[5]  = '{1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[6]  = '{1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    tbl[7]  = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd16};
    tbl[8]  = '{1'b0, 1'b1, 32'd40, 1'b1, 32'd24};
    tbl[9]  = '{1'b0, 1'b1, 32'd48, 1'b1, 32'd32};
    tbl[10] = '{1'b0, 1'b1, 32'd56, 1'b1, 32'd40};

    reset = 1'b1; stall = 1'b0; s_reset = 1'b1; s_stall = 1'b0;
`ifdef FETCH_REDIRECT_EN
    redirect_valid = 1'b0; redirect_pc = 32'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset.fd_valid", fd_valid, 1'b0);
    chk("reset.fd_zero", fd_reg.inst_a | fd_reg.pc_a | fd_reg.pc_b, 32'h0);
    chk("reset.done", done, 1'b0);
    chk("reset.imem_req", imem_req, 1'b0);

    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      stall = tbl[i].stall;
      #1;
      chk($sformatf("tbl%0d.req", i), imem_req, tbl[i].req);
      chk($sformatf("tbl%0d.addr_a", i), imem_addr_a, tbl[i].addr);
      chk($sformatf("tbl%0d.addr_b", i), imem_addr_b, tbl[i].addr + 32'd4);
      chk($sformatf("tbl%0d.fd_valid", i), fd_valid, tbl[i].fdv);
      chk($sformatf("tbl%0d.pc_a", i), fd_reg.pc_a, tbl[i].pc_a);
      chk($sformatf("tbl%0d.inst_a", i), fd_reg.inst_a,
          tbl[i].fdv ? inst_of(tbl[i].pc_a) : 32'h0);
      step();
    end

    // Random stall run to end of the 256-word program.
    exp_pc = 32'd48; consumed = 0; prev_stall = 1'b0; prev_fd = fd_reg; prev_fdv = fd_valid;
    for (int c = 0; c < 2000 && exp_pc < 32'd1024; c++)
      cycle_sb($urandom_range(0, 99) < 30);
    chk("run.all_consumed", exp_pc, 32'd1024);
    repeat (4) cycle_sb(1'b0);
    chk("run.done", done, 1'b1);
    chk("run.fd_valid_end", fd_valid, 1'b0);
    chk("run.req_end", imem_req, 1'b0);
    chk("run.no_extra", exp_pc, 32'd1024);

    // Reset while the skid is full.
    reset = 1'b1; stall = 1'b0;
    step();
    reset = 1'b0;
    step();                      // C0
    step();                      // C1
    stall = 1'b1;                // C2: response for pc 8 goes to skid
    step();
    reset = 1'b1;                // C3: skid full, reset this edge
    #1;
    chk("rst_skid.req_in_reset", imem_req, 1'b0);
    step();
    chk("rst_skid.fd_valid", fd_valid, 1'b0);
    chk("rst_skid.fd_zero", fd_reg.inst_a | fd_reg.inst_b | fd_reg.pc_a | fd_reg.pc_b, 32'h0);
    chk("rst_skid.done", done, 1'b0);
    chk("rst_skid.req", imem_req, 1'b0);
    reset = 1'b0; stall = 1'b0;
    #1;
    chk("restart.req", imem_req, 1'b1);
    chk("restart.addr", imem_addr_a, 32'h0);

    // Single-cycle stall on a response cycle; stream must stay continuous.
    exp_pc = 32'h0; consumed = 0; prev_stall = 1'b0; prev_fd = fd_reg; prev_fdv = fd_valid;
    for (int c = 0; c < 10; c++) cycle_sb(c == 3);
    chk("pulse.consumed", consumed, 7);
    chk("pulse.next_pc", exp_pc, 32'd56);

`ifdef FETCH_REDIRECT_EN
    // Redirect while stalled with the skid full.
    stall = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("redir.req", imem_req, 1'b0);
    step();
    redirect_valid = 1'b0;
    chk("redir.fd_valid", fd_valid, 1'b0);
    exp_pc = 32'h40; consumed = 0; prev_stall = 1'b0;
    for (int c = 0; c < 6; c++) cycle_sb(1'b0);
    chk("redir.consumed", consumed, 4);
`endif

    // End of program on the 8-word instance.
    s_reset = 1'b0;
    #1;
    chk("eop.c0_req", s_imem_req, 1'b1);
    step(); step();              // C2
    chk("eop.c2_valid", s_fd_valid, 1'b1);
    chk("eop.c2_pc_a", s_fd.pc_a, 32'd0);
    step();                      // C3
    chk("eop.c3_req", s_imem_req, 1'b1);
    chk("eop.c3_addr", s_addr_a, 32'd24);
    step();                      // C4
    chk("eop.c4_req", s_imem_req, 1'b0);
    chk("eop.c4_pc_a", s_fd.pc_a, 32'd16);
    step();                      // C5
    chk("eop.c5_pc_a", s_fd.pc_a, 32'd24);
    chk("eop.c5_inst_b", s_fd.inst_b, inst_of(32'd28));
    chk("eop.c5_req", s_imem_req, 1'b0);
    step();                      // C6
    chk("eop.c6_valid", s_fd_valid, 1'b0);
    chk("eop.c6_req", s_imem_req, 1'b0);
    chk("eop.c6_done", s_done, 1'b0);
    step();                      // C7
    chk("eop.c7_done", s_done, 1'b1);
    c0 = 0;
    repeat (3) begin
      step();
      c0++;
    end
    chk("eop.sticky_done", s_done, 1'b1);
    chk("eop.no_req", s_imem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Dual-issue instruction fetch stage. It owns the PC and issues paired requests to a synchronous-read instruction memory. It buffers one in-flight response and drives the `fd_reg` fetch/decode pipeline register (`fetchStruct`: `inst_a`, `inst_b`, `pc_a`, `pc_b`) consumed by decode. It is the producer end of the fetch→decode interface and adds stall back-pressure and end-of-program detection.

## Interface
- `IMEM_DEPTH`, default 256: instruction memory size in 32-bit words. Must be even.
- `RESET_PC`, default 32'h0: PC loaded on reset. Must be 8-byte aligned.
- `clk` in 1: clock.
- `reset` in 1: reset. Synchronous, active-high.
- `stall` in 1: decode cannot accept `fd_reg` at this edge.
- `imem_req` out 1: read request for the pair at `imem_addr_a`/`imem_addr_b`.
- `imem_addr_a` out 32: byte address of slot a, equal to `pc`.
- `imem_addr_b` out 32: `pc + 4`.
- `imem_rdata_a` in 32: slot a word. Valid exactly 1 cycle after `imem_req`.
- `imem_rdata_b` in 32: slot b word. Same timing as `imem_rdata_a`.
- `fd_reg` out `fetchStruct`: registered pair to decode.
- `fd_valid` out 1: `fd_reg` holds a real pair. When 0, `fd_reg` is all-zero, which is opcode 0 (a bubble in decode).
- `done` out 1: the whole program has been fetched and consumed.
- `redirect_valid` in 1: only with `FETCH_REDIRECT_EN`.
- `redirect_pc` in 32: only with `FETCH_REDIRECT_EN`. Word aligned.

## Operation
- **State:** `pc` (32), `running`, `inflight`, `skid_valid` plus `skid` (`fetchStruct`), and the `fd_reg`/`fd_valid` register.
- **Reset values:** `pc` = `RESET_PC`, `running` = 1, `inflight` = 0, `skid_valid` = 0, `fd_reg` = 0, `fd_valid` = 0, `done` = 0, `imem_req` = 0.
- **Request:** `imem_req = running && !stall && !reset`.
  - On a request edge: `pc += 8`, `inflight <= 1`. Otherwise `inflight <= 0`.
- **Halt:** `running` clears when the next `pc` would be ≥ `IMEM_DEPTH*4`. No requests are issued after that.
- **Response:** in a cycle with `inflight` = 1, the pair is {`imem_rdata_a`, `imem_rdata_b`, `pc_a` = `pc - 8`, `pc_b` = `pc - 4`}.
- **Register update when `stall` = 0 (fd consumed), in priority order:**
  1. `fd_reg <= skid`, `fd_valid <= 1`.
  2. Else `fd_reg <= response`, `fd_valid <= 1`.
  3. Else `fd_reg <= 0`, `fd_valid <= 0`.
- **Register update when `stall` = 1:** `fd_reg`/`fd_valid` hold. An arriving response is written to `skid` and `skid_valid <= 1`.
- **Invariant:** `skid_valid` and `inflight` are never both 1. A request needs `stall` = 0, and the skid only fills under stall. The invariant is checked by an assertion.
- **`done`:** `!running && !inflight && !skid_valid && !fd_valid`. It is sticky until reset.

## Timing
- Call C0 the first cycle with `reset` low. In C0, `imem_req` = 1 and `imem_addr_a` = `RESET_PC`.
- Data for that request arrives in C1. In C2, `fd_valid` = 1 and `fd_reg.pc_a` = `RESET_PC`.
- Fetch-to-decode latency is 2 cycles. Steady-state throughput is 2 instructions per cycle with no stall.
- Stall release: in the first cycle after release, `fd_reg` loads the skid and a new request issues in the same cycle. No bubble is inserted if the skid was full.
- Reset asserted mid-operation: at that edge all state returns to reset values. The in-flight response is dropped.
- Single-cycle stall coinciding with a response: the response goes to the skid and appears in `fd_reg` in the cycle after stall falls.

## Configuration
- `FETCH_REDIRECT_EN` defined:
  - Adds the `redirect_valid`/`redirect_pc` ports.
  - `redirect_valid` takes priority over `stall` and normal update.
  - At that edge: `pc <= redirect_pc`, `inflight <= 0` (the pending response is discarded), `skid_valid <= 0`, `fd_reg <= 0`, `fd_valid <= 0`, `done <= 0`.
  - `running` is recomputed from `redirect_pc`. No request is issued in the redirect cycle.
- `FETCH_REDIRECT_EN` undefined: the ports are absent and `pc` is strictly sequential.

## Structure
- The `typedefs` package carries the existing `fetchStruct`.
- Add to the same package:
  - `FETCH_WIDTH` = 2.
  - `FETCH_BYTES` = 8.
  - `NOP_WORD` = 32'h0.
- One sub-module, `fetch_skid`: a 1-entry `fetchStruct` holding register with `load`/`drain` controls and a `valid` output.

## Test plan
- **Plain run:** memory word i = 0x100+i, reset released at C0. Required:
  - C2: `fd_reg` {pc_a 0, pc_b 4, inst 0x100/0x101}.
  - C3: {pc 8/12, inst 0x102/0x103}.
- **Mid-stream stall:** `stall` high for 3 cycles while `fd_reg.pc_a` = 16. Required:
  - `fd_reg` holds pc_a 16 throughout the stall.
  - pc_a 24 appears in the first cycle after release, then pc_a 32.
  - No pair is lost or duplicated.
- **End of program:** `IMEM_DEPTH` = 8. Required:
  - After pc_a 24 is consumed, `imem_req` stays 0 and `fd_valid` = 0.
  - `done` = 1 one cycle later.
- **Reset with full skid:** assert `reset` while the skid is full. Required:
  - Next cycle, all outputs are 0.
  - After release, fetch restarts at `RESET_PC` and the first pair has pc_a = `RESET_PC`.
- **Single-cycle stall on response cycle:** pulse `stall` for 1 cycle exactly on a response cycle. Required: the sequence of pc_a values seen by decode on consuming edges is continuous (…8, 16, 24…).
- **Redirect (`FETCH_REDIRECT_EN`):** `redirect_pc` = 0x40 while `stall` = 1 and the skid is full. Required:
  - Next cycle, `fd_valid` = 0.
  - The next valid pair has pc_a 0x40.
  - No stale pair appears.
